// File: rtl/mem_arbiter.sv
// Arbitrates Icache read-fill, Dcache read-fill and Dcache write-back onto one
// main-memory port using a four-phase enable/ack handshake.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data_out,
    input  logic [LINE_W-1:0] mem_data_in,
    input  logic              mem_ack
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WAIT_LOW} state_t;
    typedef enum logic [1:0] {OWN_IC, OWN_DR, OWN_DW} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_out_q, mem_data_out_d;
    logic              ic_read_ack_q, ic_read_ack_d;
    logic              dc_read_ack_q, dc_read_ack_d;
    logic              dc_write_ack_q, dc_write_ack_d;
    logic [LINE_W-1:0] ic_read_data_q, ic_read_data_d;
    logic [LINE_W-1:0] dc_read_data_q, dc_read_data_d;

    logic any_req, starved;

    assign any_req = ic_read_req | dc_read_req | dc_write_req;
    assign starved = ic_read_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_cnt_d   = starve_cnt_q;
        mem_enable_d   = mem_enable_q;
        mem_rw_d       = mem_rw_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        ic_read_data_d = ic_read_data_q;
        dc_read_data_d = dc_read_data_q;
        // acks are only ever high for the single RESP cycle
        ic_read_ack_d  = 1'b0;
        dc_read_ack_d  = 1'b0;
        dc_write_ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                // a lingering mem_ack from an abandoned transaction blocks grants
                if (any_req && !mem_ack) begin
                    if (starved || !(dc_write_req || dc_read_req)) owner_d = OWN_IC;
                    else if (dc_write_req)                         owner_d = OWN_DW;
                    else                                           owner_d = OWN_DR;

                    if (owner_d != OWN_IC && ic_read_req) begin
                        if (starve_cnt_q != CNT_W'(STARVE_LIMIT))
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end

                    mem_enable_d = 1'b1;
                    mem_rw_d     = (owner_d == OWN_DW);
                    case (owner_d)
                        OWN_DW:  begin
                            mem_addr_d     = dc_write_addr;
                            mem_data_out_d = dc_write_data;
                        end
                        OWN_DR:  mem_addr_d = dc_read_addr;
                        default: mem_addr_d = ic_read_addr;
                    endcase
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_enable_d = 1'b0;
                    case (owner_q)
                        OWN_DW: dc_write_ack_d = 1'b1;
                        OWN_DR: begin
                            dc_read_ack_d  = 1'b1;
                            dc_read_data_d = mem_data_in;
                        end
                        default: begin
                            ic_read_ack_d  = 1'b1;
                            ic_read_data_d = mem_data_in;
                        end
                    endcase
                    state_d = RESP;
                end
            end
            RESP:     state_d = WAIT_LOW;
            WAIT_LOW: if (!mem_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IC;
            starve_cnt_q   <= '0;
            mem_enable_q   <= 1'b0;
            mem_rw_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            ic_read_ack_q  <= 1'b0;
            dc_read_ack_q  <= 1'b0;
            dc_write_ack_q <= 1'b0;
            ic_read_data_q <= '0;
            dc_read_data_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            starve_cnt_q   <= starve_cnt_d;
            mem_enable_q   <= mem_enable_d;
            mem_rw_q       <= mem_rw_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            ic_read_ack_q  <= ic_read_ack_d;
            dc_read_ack_q  <= dc_read_ack_d;
            dc_write_ack_q <= dc_write_ack_d;
            ic_read_data_q <= ic_read_data_d;
            dc_read_data_q <= dc_read_data_d;
        end
    end

    assign mem_enable   = mem_enable_q;
    assign mem_rw       = mem_rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_data_out_q;
    assign ic_read_ack  = ic_read_ack_q;
    assign dc_read_ack  = dc_read_ack_q;
    assign dc_write_ack = dc_write_ack_q;
    assign ic_read_data = ic_read_data_q;
    assign dc_read_data = dc_read_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester and memory models drive the DUT,
// a transaction-level reference model predicts every output each cycle.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ic_read_ack, dc_read_ack, dc_write_ack;
    logic [127:0] ic_read_data, dc_read_data;
    logic         mem_enable, mem_rw;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data_out;
    logic [127:0] mem_data_in = '0;
    logic         mem_ack = 1'b0;

    // requester channels: 0 = ic read, 1 = dc read, 2 = dc write
    logic         r_req [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0]  r_addr[3] = '{32'h0, 32'h0, 32'h0};
    logic [127:0] w_data = '0;
    bit           drop_next[3] = '{0, 0, 0};
    int           p_req[3] = '{0, 0, 0};
    int           rst_pct = 0;
    logic [31:0]  base[3] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};

    // memory model knobs
    int  dmin = 0, dmax = 3, hmin = 1, hmax = 4;
    int  m_dly = -1, m_hold = 0;
    bit  fix_data = 0;

    int n_checks = 0, n_errors = 0;

    // reference model
    bit           m_ready = 1, m_busy = 0, m_resp = 0;
    int           m_own = 0, m_starve = 0;
    logic         e_en = 0, e_rw = 0;
    logic [31:0]  e_addr = '0;
    logic [127:0] e_dout = '0, e_icd = '0, e_dcd = '0;
    logic [2:0]   e_ack = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ic_read_req(r_req[0]), .ic_read_addr(r_addr[0]),
        .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
        .dc_read_req(r_req[1]), .dc_read_addr(r_addr[1]),
        .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
        .dc_write_req(r_req[2]), .dc_write_addr(r_addr[2]),
        .dc_write_data(w_data), .dc_write_ack(dc_write_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ack(mem_ack)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Predicts the outputs after the coming edge from the inputs held across it.
    task automatic model_edge();
        int w;
        e_ack = '0;
        if (reset) begin
            m_ready = 1; m_busy = 0; m_resp = 0; m_starve = 0;
            e_en = 0; e_rw = 0; e_addr = '0; e_dout = '0; e_icd = '0; e_dcd = '0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0; m_resp = 1; e_en = 0;
                e_ack[m_own] = 1'b1;
                if (m_own == 0) e_icd = mem_data_in;
                if (m_own == 1) e_dcd = mem_data_in;
            end
        end else if (m_resp) begin
            m_resp = 0;
        end else if (!m_ready) begin
            if (!mem_ack) m_ready = 1;
        end else if ((r_req[0] || r_req[1] || r_req[2]) && !mem_ack) begin
            if (m_starve == LIMIT && r_req[0]) w = 0;
            else if (r_req[2])                 w = 2;
            else if (r_req[1])                 w = 1;
            else                               w = 0;
            if (w != 0 && r_req[0]) m_starve = (m_starve < LIMIT) ? m_starve + 1 : m_starve;
            else                    m_starve = 0;
            m_own = w; m_busy = 1; m_ready = 0;
            e_en = 1; e_rw = (w == 2); e_addr = r_addr[w];
            if (w == 2) e_dout = w_data;
        end
    endtask

    task automatic check_outputs();
        chk("mem_enable", mem_enable, e_en);
        chk("mem_rw", mem_rw, e_rw);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data_out", mem_data_out, e_dout);
        chk("acks", {dc_write_ack, dc_read_ack, ic_read_ack}, e_ack);
        chk("ic_read_data", ic_read_data, e_icd);
        chk("dc_read_data", dc_read_data, e_dcd);
    endtask

    task automatic drive();
        logic [2:0] acks;
        acks = {dc_write_ack, dc_read_ack, ic_read_ack};
        for (int c = 0; c < 3; c++) begin
            if (drop_next[c]) begin
                r_req[c] = 1'b0; drop_next[c] = 0;
            end else if (acks[c]) begin
                if ($urandom_range(1, 0) == 1) r_req[c] = 1'b0;
                else                           drop_next[c] = 1;
            end else if (!r_req[c] && $urandom_range(99, 0) < p_req[c]) begin
                r_req[c]  = 1'b1;
                r_addr[c] = base[c] | ($urandom & 32'h0000_fff0);
                if (c == 2) w_data = rand128();
            end
        end
        // memory: random response delay, ack held for a random number of cycles
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) mem_ack = 1'b0;
        end else if (mem_enable) begin
            if (m_dly < 0) m_dly = $urandom_range(dmax, dmin);
            if (m_dly == 0) begin
                mem_ack     = 1'b1;
                mem_data_in = fix_data ? {16{8'hA5}} : rand128();
                m_hold      = $urandom_range(hmax, hmin);
                m_dly       = -1;
            end else begin
                m_dly--;
            end
        end else begin
            m_dly = -1;
        end
        reset = ($urandom_range(99, 0) < rst_pct);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            check_outputs();
            drive();
        end
    endtask

    initial begin
        run(2);
        reset = 1'b0;

        // single ic read, ack three cycles after enable
        fix_data = 1; dmin = 2; dmax = 2; hmin = 1; hmax = 1;
        r_addr[0] = 32'h100; r_req[0] = 1'b1;
        run(12);
        chk("ic_a5_line", ic_read_data, {16{8'hA5}});
        fix_data = 0;

        // all three at once: write-back first, then dc read, then ic read
        dmin = 1; dmax = 1;
        r_addr[0] = 32'h0001_0040; r_addr[1] = 32'h0002_0080; r_addr[2] = 32'h2000;
        w_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        r_req[0] = 1'b1; r_req[1] = 1'b1; r_req[2] = 1'b1;
        run(30);

        // sticky mem_ack held for five cycles
        hmin = 5; hmax = 5;
        r_addr[1] = 32'h0002_0100; r_req[1] = 1'b1;
        run(20);

        // random traffic with occasional mid-transaction resets
        dmin = 0; dmax = 3; hmin = 1; hmax = 4;
        p_req = '{30, 30, 30}; rst_pct = 2;
        run(3000);

        // starvation pressure: Dcache re-requests back-to-back while Icache waits
        rst_pct = 0; reset = 1'b0;
        p_req = '{100, 50, 100};
        run(1500);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
